// File: rtl/mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_seq: W-bit sequential MSB-first shift-add multiplier, signed/unsigned  |
// |          per operation, 2W-bit product after W step cycles.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mul_seq #(
    parameter int W = 8
) (
    input  logic             ck,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   o,
    output logic             busy,
    output logic             fin
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [0:0]    c_st_idle = 1'b0;
    localparam logic [0:0]    c_st_run  = 1'b1;
    localparam logic [CW-1:0] c_last    = CW'(W - 1);

    logic [0:0]     r_state;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_areg;
    logic [W-1:0]   r_breg;
    logic           r_mode;

    logic [2*W-1:0] w_ext;
    logic [2*W-1:0] w_pp;
    logic [2*W-1:0] w_next;

    // In signed mode the multiplier MSB carries weight -2^(W-1), so that
    // partial product is subtracted rather than added.
    always_comb begin
        w_ext  = r_mode ? {{W{r_areg[W-1]}}, r_areg} : {{W{1'b0}}, r_areg};
        w_pp   = '0;
        if (r_breg[r_cnt]) begin
            w_pp = (r_mode && (r_cnt == c_last)) ? (~w_ext + 1'b1) : w_ext;
        end
        w_next = {o[2*W-2:0], 1'b0} + w_pp;
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_areg  <= '0;
            r_breg  <= '0;
            r_mode  <= 1'b0;
            o       <= '0;
            busy    <= 1'b0;
            fin     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    fin <= 1'b0;
                    if (start) begin
                        r_areg  <= a;
                        r_breg  <= b;
                        r_mode  <= sgn;
                        o       <= '0;
                        r_cnt   <= c_last;
                        r_state <= c_st_run;
                        busy    <= 1'b1;
                    end
                end
                c_st_run: begin
                    o <= w_next;
                    if (r_cnt == '0) begin
                        r_state <= c_st_idle;
                        busy    <= 1'b0;
                        fin     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    busy    <= 1'b0;
                    fin     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mul_seq: scoreboard bench for mul_seq (W=8) with random and directed    |
// |             operands against an arithmetic reference model.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mul_seq;

    localparam int W = 8;

    logic          ck = 1'b0;
    logic          rst;
    logic          start;
    logic          sgn;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [2*W-1:0] o;
    logic          busy;
    logic          fin;

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] expq[$];

    mul_seq #(.W(W)) dut (
        .ck    (ck),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .o     (o),
        .busy  (busy),
        .fin   (fin)
    );

    always #5 ck = ~ck;

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic s);
        longint vx;
        longint vy;
        vx = s ? longint'($signed(x)) : longint'(x);
        vy = s ? longint'($signed(y)) : longint'(y);
        return (2*W)'(vx * vy);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge ck);
    endtask

    task automatic scramble();
        a   = 8'($urandom);
        b   = 8'($urandom);
        sgn = 1'($urandom);
    endtask

    // One operation from idle; optional stray start pulses before E3 and E5.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts,
                          input bit glitch);
        logic [2*W-1:0] e;
        a = ta; b = tbv; sgn = ts; start = 1'b1;
        e = ref_mul(ta, tbv, ts);
        expq.push_back(e);
        tick();
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("fin_after_accept", 32'(fin), 32'd0);
        for (int k = 1; k <= W; k++) begin
            start = glitch && (k == 3 || k == 5);
            scramble();
            tick();
            if (k < W) begin
                chk("busy_run", 32'(busy), 32'd1);
                chk("fin_run", 32'(fin), 32'd0);
            end else begin
                chk("busy_done", 32'(busy), 32'd0);
                chk("fin_done", 32'(fin), 32'd1);
            end
        end
        start = 1'b0;
        tick();
        chk("fin_one_cycle", 32'(fin), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("o_hold", 32'(o), 32'(e));
    endtask

    // Start held high; second operands presented during the first fin cycle.
    task automatic b2b(input logic [W-1:0] a1, input logic [W-1:0] b1, input logic s1,
                       input logic [W-1:0] a2, input logic [W-1:0] b2, input logic s2);
        a = a1; b = b1; sgn = s1; start = 1'b1;
        expq.push_back(ref_mul(a1, b1, s1));
        tick();
        for (int k = 1; k <= W; k++) begin
            scramble();
            tick();
        end
        chk("b2b_fin1", 32'(fin), 32'd1);
        a = a2; b = b2; sgn = s2;
        expq.push_back(ref_mul(a2, b2, s2));
        tick();
        chk("b2b_o_cleared", 32'(o), 32'd0);
        chk("b2b_busy2", 32'(busy), 32'd1);
        chk("b2b_fin_low", 32'(fin), 32'd0);
        for (int k = 1; k < W; k++) begin
            scramble();
            tick();
        end
        tick();
        start = 1'b0;
        chk("b2b_fin2", 32'(fin), 32'd1);
        chk("b2b_busy_end", 32'(busy), 32'd0);
        tick();
        chk("b2b_no_third", 32'(busy), 32'd0);
    endtask

    // Scoreboard monitor: every fin pulse must match the oldest outstanding op.
    initial begin
        logic [2*W-1:0] e;
        forever begin
            @(negedge ck);
            if (fin === 1'b1) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_fin actual=fin(o=%h) expected=no_fin at %0t", o, $time);
                end else begin
                    e = expq.pop_front();
                    chk("product", 32'(o), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; sgn = 1'b0;
        tick();
        tick();
        chk("reset_o", 32'(o), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_fin", 32'(fin), 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();
        chk("post_reset_idle", 32'(busy), 32'd0);
        chk("post_reset_o", 32'(o), 32'd0);

        run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        run_op(8'hFD, 8'h05, 1'b0, 1'b0);
        run_op(8'h80, 8'h80, 1'b1, 1'b0);
        run_op(8'hFD, 8'h05, 1'b1, 1'b0);
        run_op(8'h05, 8'hFD, 1'b1, 1'b0);
        run_op(8'h7F, 8'h80, 1'b1, 1'b0);
        run_op(8'h80, 8'h7F, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);
        run_op(8'h00, 8'hA5, 1'b1, 1'b0);
        run_op(8'h3C, 8'h96, 1'b0, 1'b1);
        run_op(8'h80, 8'hFF, 1'b1, 1'b1);

        b2b(8'hFF, 8'hFF, 1'b0, 8'h80, 8'h80, 1'b1);

        // Reset in the middle of a run.
        a = 8'h77; b = 8'h99; sgn = 1'b0; start = 1'b1;
        expq.push_back(ref_mul(8'h77, 8'h99, 1'b0));
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        expq.delete();
        chk("abort_o", 32'(o), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_fin", 32'(fin), 32'd0);
        rst = 1'b0;
        for (int k = 5; k <= 12; k++) begin
            tick();
            chk("abort_no_fin", 32'(fin), 32'd0);
        end

        // Reset then an immediate start on the following edge.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_op(8'h12, 8'h34, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) begin
            b2b(8'($urandom), 8'($urandom), 1'($urandom),
                8'($urandom), 8'($urandom), 1'($urandom));
        end

        tick(); tick(); tick();
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
